// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch control unit: state encoding and clock rate.
package stopwatch_ctrl_pkg;

  localparam int CLK_HZ         = 100_000_000;
  localparam int LONG_PRESS_DEF = 2 * CLK_HZ;

  localparam logic [2:0] ST_STOP       = 3'd0;
  localparam logic [2:0] ST_RUN        = 3'd1;
  localparam logic [2:0] ST_CLR        = 3'd2;
  localparam logic [2:0] ST_ERASE_CLR  = 3'd3;
  localparam logic [2:0] ST_ERASE_SAVE = 3'd4;

endpackage

// File: rtl/stopwatch_ctrl_btn_edge_sync.sv
// Button input path: 2-flop synchroniser, previous-level flop, registered rising-edge pulse.
// Pulse appears 3 clk edges after the level rises; level output is the synchronised s2.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
      rise <= s2 & ~prev;
    end
  end

  assign level = s2;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/stop level, clear/save/restore strobes, long-press erase.
// Button rise to registered output change is 3 clk cycles; no backpressure from the datapath.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int LONG_PRESS = LONG_PRESS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_lap,
  output logic       o_runstop,
  output logic       o_clear,
  output logic       o_save,
  output logic       o_restore,
  output logic       o_lap_valid,
  output logic [2:0] o_state
);

  localparam int HOLD_W = $clog2(LONG_PRESS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS - 1);

  logic              rise_run;
  logic              rise_clear;
  logic              rise_lap;
  logic              lvl_clear;
  logic [2:0]        state;
  logic [HOLD_W-1:0] hold;

  btn_edge_sync u_sync_run (
    .clk(clk), .rst(rst), .btn(i_btn_run), .level(), .rise(rise_run)
  );
  btn_edge_sync u_sync_clear (
    .clk(clk), .rst(rst), .btn(i_btn_clear), .level(lvl_clear), .rise(rise_clear)
  );
  btn_edge_sync u_sync_lap (
    .clk(clk), .rst(rst), .btn(i_btn_lap), .level(), .rise(rise_lap)
  );

  // Only the highest-priority edge of a cycle survives; the rest are dropped.
  logic run_e;
  logic clr_e;
  logic lap_e;
  logic erase_go;

  assign run_e    = i_en & rise_run;
  assign clr_e    = i_en & rise_clear & ~rise_run;
  assign lap_e    = i_en & rise_lap & ~rise_run & ~rise_clear;
  assign erase_go = i_en && (state == ST_STOP) && (hold == HOLD_FIRE);

  // Erase states pin the counter at saturation so one press erases only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (!lvl_clear) begin
      hold <= '0;
    end else begin
      case (state)
        ST_STOP, ST_CLR:             hold <= (hold == HOLD_MAX) ? hold : hold + 1'b1;
        ST_ERASE_CLR, ST_ERASE_SAVE: hold <= HOLD_MAX;
        default:                     hold <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_STOP;
      o_runstop   <= 1'b0;
      o_clear     <= 1'b0;
      o_save      <= 1'b0;
      o_restore   <= 1'b0;
      o_lap_valid <= 1'b0;
    end else begin
      o_clear   <= 1'b0;
      o_save    <= 1'b0;
      o_restore <= 1'b0;
      case (state)
        ST_STOP: begin
          if (erase_go) begin
            state   <= ST_ERASE_CLR;
            o_clear <= 1'b1;
          end else if (run_e) begin
            state     <= ST_RUN;
            o_runstop <= 1'b1;
          end else if (clr_e) begin
            state   <= ST_CLR;
            o_clear <= 1'b1;
          end else if (lap_e && o_lap_valid) begin
            o_restore <= 1'b1;
          end
        end
        ST_RUN: begin
          if (run_e) begin
            state     <= ST_STOP;
            o_runstop <= 1'b0;
          end else if (lap_e) begin
            o_save      <= 1'b1;
            o_lap_valid <= 1'b1;
          end
        end
        ST_CLR: begin
          state <= ST_STOP;
        end
        ST_ERASE_CLR: begin
          state       <= ST_ERASE_SAVE;
          o_save      <= 1'b1;
          o_lap_valid <= 1'b0;
        end
        default: begin
          state     <= ST_STOP;
          o_runstop <= 1'b0;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl: a cycle model pushes expected outputs, a monitor compares.
module tb_stopwatch_ctrl;

  localparam int LP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_en = 1'b0;
  logic       b_run = 1'b0;
  logic       b_clr = 1'b0;
  logic       b_lap = 1'b0;
  logic       o_runstop, o_clear, o_save, o_restore, o_lap_valid;
  logic [2:0] o_state;

  stopwatch_ctrl #(.LONG_PRESS(LP)) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_btn_run(b_run), .i_btn_clear(b_clr), .i_btn_lap(b_lap),
    .o_runstop(o_runstop), .o_clear(o_clear), .o_save(o_save),
    .o_restore(o_restore), .o_lap_valid(o_lap_valid), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_clr = 0;
  int n_sav = 0;
  int n_rsto = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected output word: {state, runstop, clear, save, restore, lap_valid}
  logic [7:0] exp_q[$];

  // Reference model: button levels as sampled each clk, with the 3-cycle input latency
  // expressed as a look-back into that sample history.
  int       m_st = 0;
  int       m_hold = 0;
  bit       m_lv = 0, m_clr = 0, m_sav = 0, m_rsto = 0;
  bit [4:0] h_run = '0, h_clr = '0, h_lap = '0;

  always @(posedge clk) begin
    int  pick;
    int  old_st;
    int  old_hold;
    bit  s2c;
    if (rst) begin
      m_st = 0; m_hold = 0; m_lv = 0; m_clr = 0; m_sav = 0; m_rsto = 0;
      h_run = '0; h_clr = '0; h_lap = '0;
    end else begin
      h_run = {h_run[3:0], b_run};
      h_clr = {h_clr[3:0], b_clr};
      h_lap = {h_lap[3:0], b_lap};
      s2c = h_clr[2];
      pick = 0;
      if (i_en) begin
        if (h_run[3] && !h_run[4])      pick = 1;
        else if (h_clr[3] && !h_clr[4]) pick = 2;
        else if (h_lap[3] && !h_lap[4]) pick = 3;
      end
      old_st = m_st;
      old_hold = m_hold;
      if (!s2c)                         m_hold = 0;
      else if (old_st == 0 || old_st == 2) m_hold = (m_hold < LP) ? m_hold + 1 : LP;
      else if (old_st >= 3)             m_hold = LP;
      else                              m_hold = 0;
      m_clr = 0; m_sav = 0; m_rsto = 0;
      case (old_st)
        0: begin
          if (i_en && old_hold == LP - 1) begin m_st = 3; m_clr = 1; end
          else if (pick == 1) m_st = 1;
          else if (pick == 2) begin m_st = 2; m_clr = 1; end
          else if (pick == 3 && m_lv) m_rsto = 1;
        end
        1: begin
          if (pick == 1) m_st = 0;
          else if (pick == 3) begin m_sav = 1; m_lv = 1; end
        end
        2: m_st = 0;
        3: begin m_st = 4; m_sav = 1; m_lv = 0; end
        default: m_st = 0;
      endcase
    end
    exp_q.push_back({3'(m_st), (m_st == 1), m_clr, m_sav, m_rsto, m_lv});
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst) begin
        chk("outputs", {o_state, o_runstop, o_clear, o_save, o_restore, o_lap_valid}, e);
        n_clr  += int'(o_clear);
        n_sav  += int'(o_save);
        n_rsto += int'(o_restore);
      end
    end
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: b_run = v;
      1: b_clr = v;
      default: b_lap = v;
    endcase
  endtask

  task automatic press(input int which, input int len);
    set_btn(which, 1'b1);
    repeat (len) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int c0, s0, r0;
    bit found;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_state, o_runstop, o_clear, o_save, o_restore, o_lap_valid}, 8'h00);
    rst = 1'b0;
    i_en = 1'b1;
    repeat (3) @(negedge clk);

    // run start latency: rise before edge N, change visible after N+3
    b_run = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_latency_before", o_runstop, 0);
    @(negedge clk);
    chk("run_latency_after", o_runstop, 1);
    chk("run_state", o_state, 1);
    b_run = 1'b0;
    repeat (6) @(negedge clk);
    press(0, 3);
    chk("stop_state", o_state, 0);

    r0 = n_rsto;
    press(2, 3);
    chk("no_restore_without_lap", n_rsto - r0, 0);

    press(0, 3);
    c0 = n_clr;
    press(1, 3);
    chk("clear_ignored_in_run", n_clr - c0, 0);
    chk("still_run", o_state, 1);
    s0 = n_sav;
    press(2, 3);
    chk("lap_save_count", n_sav - s0, 1);
    chk("lap_valid_set", o_lap_valid, 1);

    // run and lap rising together in RUN: run wins, lap dropped
    s0 = n_sav;
    b_run = 1'b1; b_lap = 1'b1;
    repeat (3) @(negedge clk);
    b_run = 1'b0; b_lap = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_lap_state", o_state, 0);
    chk("run_lap_no_save", n_sav - s0, 0);

    r0 = n_rsto;
    press(2, 3);
    chk("restore_count", n_rsto - r0, 1);
    chk("restore_runstop", o_runstop, 0);

    // long press in STOP: CLR, then ERASE_CLR + ERASE_SAVE once only
    c0 = n_clr; s0 = n_sav;
    press(1, 40);
    chk("long_clear_count", n_clr - c0, 2);
    chk("long_save_count", n_sav - s0, 1);
    chk("long_lap_valid", o_lap_valid, 0);
    chk("long_state", o_state, 0);

    // disabled: no edges acted on, and a level already high at enable is not an edge
    i_en = 1'b0;
    c0 = n_clr; s0 = n_sav;
    press(0, 3);
    press(1, 3);
    press(2, 3);
    chk("disabled_state", o_state, 0);
    chk("disabled_strobes", (n_clr - c0) + (n_sav - s0), 0);
    b_run = 1'b1;
    repeat (6) @(negedge clk);
    i_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("level_at_enable", o_state, 0);
    b_run = 1'b0;
    repeat (4) @(negedge clk);

    // i_en falling while running keeps the count going
    press(0, 3);
    i_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("bg_run_state", o_state, 1);
    chk("bg_runstop", o_runstop, 1);
    i_en = 1'b1;
    press(0, 3);

    // async reset in ERASE_CLR
    b_clr = 1'b1;
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (o_state == 3'd3) found = 1;
    end
    chk("reach_erase_clr", found, 1);
    s0 = n_sav;
    rst = 1'b1;
    #1;
    chk("async_reset", {o_state, o_runstop, o_clear, o_save, o_restore, o_lap_valid}, 8'h00);
    b_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("after_reset_no_save", n_sav - s0, 0);
    chk("after_reset_state", o_state, 0);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) b_run = ~b_run;
      if ($urandom_range(0, 5) == 0) b_clr = ~b_clr;
      if ($urandom_range(0, 5) == 0) b_lap = ~b_lap;
      if ($urandom_range(0, 40) == 0) i_en = ~i_en;
      if ($urandom_range(0, 400) == 0) begin
        i_en = 1'b1;
        b_clr = 1'b1;
        repeat ($urandom_range(LP, LP + 10)) @(negedge clk);
      end
      @(negedge clk);
    end
    b_run = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
